// File: rtl/wmb_store_arbiter.sv
// wmb_store_arbiter: round-robin arbiter with grant lock that shares the
// write-merge-buffer store port between NUM_REQ requesters, plus a MEMBAR
// fence sequencer (quiesce -> flush -> ack).
// Optional statistics counters are compiled in with `define WMB_ARB_STATS_EN.
module wmb_store_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  input  logic [NUM_REQ*4-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    wmb_valid,
  output logic [31:0]             wmb_addr,
  output logic [31:0]             wmb_wdata,
  output logic [3:0]              wmb_wstrb,
  input  logic                    wmb_ready,
  output logic                    wmb_flush,
  input  logic                    wmb_busy,
  input  logic                    fence_req,
  output logic                    fence_ack,
  output logic [IDX_W-1:0]        grant_idx
`ifdef WMB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   stat_grant_cnt,
  output logic [15:0]             stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_FENCE_QUIESCE = 2'd1,
    ST_FENCE_FLUSH   = 2'd2,
    ST_FENCE_ACK     = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   lock_idx;
  logic               locked;
  logic               fence_armed;

  logic [IDX_W-1:0]   rr_pick;
  logic               rr_found;
  logic [IDX_W-1:0]   grant;
  logic               grant_valid;
  logic               fence_start;
  logic               store_vld;
  logic               store_hs;
  logic               store_stall;

  // Next round-robin pointer after serving requester i (wraps at NUM_REQ,
  // which need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    int cand;
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'(cand);
      end
    end
  end

  // Grant selection: a held lock always wins (it may still finish while the
  // fence quiesces); fresh grants only in IDLE and never on the cycle a fence
  // is being accepted.
  always_comb begin
    fence_start = (state == ST_IDLE) && fence_req && fence_armed;
    grant       = '0;
    grant_valid = 1'b0;
    if (locked && (state == ST_IDLE || state == ST_FENCE_QUIESCE)) begin
      grant       = lock_idx;
      grant_valid = 1'b1;
    end else if (state == ST_IDLE && !fence_start && rr_found) begin
      grant       = rr_pick;
      grant_valid = 1'b1;
    end
  end

  assign store_vld   = grant_valid && req_valid[grant];
  assign store_hs    = store_vld && wmb_ready;
  assign store_stall = store_vld && !wmb_ready;

  // Output muxing; every output is held at zero while reset is asserted.
  always_comb begin
    req_ready = '0;
    wmb_valid = 1'b0;
    wmb_addr  = '0;
    wmb_wdata = '0;
    wmb_wstrb = '0;
    wmb_flush = 1'b0;
    fence_ack = 1'b0;
    grant_idx = '0;
    if (rst_n) begin
      wmb_valid = store_vld;
      wmb_flush = (state == ST_FENCE_FLUSH);
      fence_ack = (state == ST_FENCE_ACK);
      if (grant_valid) begin
        grant_idx = grant;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_valid && grant == IDX_W'(i)) begin
          req_ready[i] = wmb_ready;
          wmb_addr     = req_addr[i*32 +: 32];
          wmb_wdata    = req_wdata[i*32 +: 32];
          wmb_wstrb    = req_wstrb[i*4 +: 4];
        end
      end
    end
  end

  // Control state: fence FSM, round-robin pointer, grant lock, fence re-arm.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      locked      <= 1'b0;
      lock_idx    <= '0;
      fence_armed <= 1'b1;
    end else begin
      if (store_hs) begin
        locked <= 1'b0;
        rr_ptr <= wrap_inc(grant);
      end else if (store_stall) begin
        locked   <= 1'b1;
        lock_idx <= grant;
      end

      case (state)
        ST_IDLE: begin
          if (fence_start) begin
            state       <= ST_FENCE_QUIESCE;
            fence_armed <= 1'b0;
          end else if (!fence_req) begin
            fence_armed <= 1'b1;
          end
        end
        ST_FENCE_QUIESCE: begin
          if (!locked || store_hs) begin
            state <= ST_FENCE_FLUSH;
          end
        end
        ST_FENCE_FLUSH: begin
          if (!wmb_busy) begin
            state <= ST_FENCE_ACK;
          end
        end
        ST_FENCE_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WMB_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           stall_cnt;

  // Saturating 16-bit increment: sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-requester accepted-store counters and stalled-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (store_hs && grant == IDX_W'(i)) begin
          grant_cnt[i*16 +: 16] <= sat_inc(grant_cnt[i*16 +: 16]);
        end
      end
      if (store_stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign stat_grant_cnt = rst_n ? grant_cnt : '0;
  assign stat_stall_cnt = rst_n ? stall_cnt : '0;
`endif

endmodule

// File: tb/tb_wmb_store_arbiter.sv
// Testbench for wmb_store_arbiter: directed stimulus with a store scoreboard
// popped by a negedge monitor, plus directed fence/reset observations.
module tb_wmb_store_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ*4-1:0]  req_wstrb;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  wmb_valid;
  logic [31:0]           wmb_addr;
  logic [31:0]           wmb_wdata;
  logic [3:0]            wmb_wstrb;
  logic                  wmb_ready;
  logic                  wmb_flush;
  logic                  wmb_busy;
  logic                  fence_req;
  logic                  fence_ack;
  logic [IDX_W-1:0]      grant_idx;

  wmb_store_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready),
    .wmb_valid(wmb_valid), .wmb_addr(wmb_addr), .wmb_wdata(wmb_wdata),
    .wmb_wstrb(wmb_wstrb), .wmb_ready(wmb_ready), .wmb_flush(wmb_flush),
    .wmb_busy(wmb_busy), .fence_req(fence_req), .fence_ack(fence_ack),
    .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Fixed per-requester payload tags.
  function automatic logic [31:0] pay_addr(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [31:0] pay_data(input int i);
    return 32'h5A5A_0000 | 32'(i);
  endfunction
  function automatic logic [3:0] pay_strb(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic push(input int i);
    exp_t e;
    e.idx  = i;
    e.addr = pay_addr(i);
    e.data = pay_data(i);
    e.strb = pay_strb(i);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted store must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wmb_valid && wmb_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_store: got grant %0d, expected no store", grant_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("store_grant", 32'(grant_idx), 32'(e.idx));
        check("store_addr", wmb_addr, e.addr);
        check("store_data", wmb_wdata, e.data);
        check("store_strb", 32'(wmb_wstrb), 32'(e.strb));
        check("store_ready_onehot", 32'(req_ready), 32'(4'b0001 << e.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int flush_n, ack_n, ack_at, ack_first, ack_last, rdy_n;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    wmb_ready = 1'b1;
    wmb_busy  = 1'b0;
    fence_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*32 +: 32]  = pay_addr(i);
      req_wdata[i*32 +: 32] = pay_data(i);
      req_wstrb[i*4 +: 4]   = pay_strb(i);
    end

    // Reset: outputs forced low even with all requesters valid.
    @(negedge clk);
    check("rst_wmb_valid", 32'(wmb_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_wmb_addr", wmb_addr, 0);
    check("rst_grant_idx", 32'(grant_idx), 0);
    check("rst_wmb_flush", 32'(wmb_flush), 0);
    check("rst_fence_ack", 32'(fence_ack), 0);
    tick();
    tick();
    rst_n     = 1'b1;
    req_valid = 4'h0;

    // T1: all valid, ready high -> grants 0,1,2,3,0.
    push(0); push(1); push(2); push(3); push(0);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t1_ready_single", 32'($countones(req_ready)), 1);
      tick();
    end
    req_valid = 4'h0;
    tick();

    // T2: rr_ptr=1. Req2 alone gets the grant, stalls 3 cycles while 0,1 join.
    wmb_ready = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    check("t2_grant_first", 32'(grant_idx), 2);
    check("t2_valid_first", 32'(wmb_valid), 1);
    check("t2_ready_first", 32'(req_ready), 0);
    tick();
    req_valid = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t2_grant_locked", 32'(grant_idx), 2);
      check("t2_addr_locked", wmb_addr, pay_addr(2));
      check("t2_ready_locked", 32'(req_ready), 0);
      tick();
    end
    wmb_ready = 1'b1;
    push(2);
    tick();
    req_valid = 4'b0011;
    push(0);
    tick();
    req_valid = 4'b0010;
    push(1);
    tick();
    req_valid = 4'b0000;
    tick();

    // T3: fence with empty buffer and idle requesters (rr_ptr=2 afterwards).
    flush_n = 0; ack_n = 0; ack_at = -1; rdy_n = 0;
    fence_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) fence_req = 1'b0;
      @(negedge clk);
      if (wmb_flush) flush_n++;
      if (fence_ack) begin ack_n++; ack_at = k; end
      if (req_ready != 0) rdy_n++;
      tick();
    end
    check("t3_flush_cycles", 32'(flush_n), 1);
    check("t3_ack_count", 32'(ack_n), 1);
    check("t3_ack_cycle", 32'(ack_at), 3);
    check("t3_ready_during_fence", 32'(rdy_n), 0);

    // T4: req1 locked when fence arrives; buffer busy 5 flush cycles.
    wmb_ready = 1'b0;
    req_valid = 4'b0010;
    push(1);
    @(negedge clk);
    check("t4_grant_lock", 32'(grant_idx), 1);
    tick();
    flush_n = 0; ack_n = 0; ack_at = -1; rdy_n = 0;
    fence_req = 1'b1;
    wmb_busy  = 1'b1;
    req_valid = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2)  fence_req = 1'b0;
      if (k == 3)  wmb_ready = 1'b1;
      if (k == 4)  req_valid = 4'b0001;
      if (k == 9)  wmb_busy  = 1'b0;
      if (k == 11) begin req_valid = 4'hF; push(2); end
      if (k == 12) req_valid = 4'h0;
      @(negedge clk);
      if (k <= 10) begin
        if (wmb_flush) flush_n++;
        if (fence_ack) begin ack_n++; ack_at = k; end
        if (req_ready != 0) rdy_n++;
      end
      tick();
    end
    check("t4_flush_cycles", 32'(flush_n), 6);
    check("t4_ack_count", 32'(ack_n), 1);
    check("t4_ack_cycle", 32'(ack_at), 10);
    check("t4_ready_in_fence", 32'(rdy_n), 1);

    // T5: fence_req held 10 cycles, then low, then a new request.
    ack_n = 0; ack_first = -1; ack_last = -1;
    for (int k = 0; k < 17; k++) begin
      fence_req = (k < 10) || (k == 11);
      @(negedge clk);
      if (fence_ack) begin
        ack_n++;
        if (ack_first < 0) ack_first = k;
        ack_last = k;
      end
      tick();
    end
    fence_req = 1'b0;
    check("t5_ack_total", 32'(ack_n), 2);
    check("t5_ack_first", 32'(ack_first), 3);
    check("t5_ack_second", 32'(ack_last), 14);

    // T6: reset during FENCE_FLUSH abandons the fence (rr_ptr was 3).
    wmb_busy  = 1'b1;
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    tick();
    @(negedge clk);
    check("t6_in_flush", 32'(wmb_flush), 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_flush", 32'(wmb_flush), 0);
    check("t6_rst_ack", 32'(fence_ack), 0);
    tick();
    rst_n    = 1'b1;
    wmb_busy = 1'b0;
    flush_n = 0; ack_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wmb_flush) flush_n++;
      if (fence_ack) ack_n++;
      tick();
    end
    check("t6_post_flush", 32'(flush_n), 0);
    check("t6_post_ack", 32'(ack_n), 0);
    req_valid = 4'hF;
    push(0);
    @(negedge clk);
    check("t6_rr_reset_grant", 32'(grant_idx), 0);
    tick();
    req_valid = 4'h0;
    tick();
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wmb_store_arbiter.md
Name: wmb_store_arbiter

Overview:
- Shares one write-merge-buffer input port between NUM_REQ store requesters (scalar LSU, vector LSU, atomics, etc.) using round-robin arbitration with grant lock.
- Sequences MEMBAR fences: stops new grants, lets any in-flight store complete, holds the buffer's flush until the buffer reports not-busy, then acknowledges the fence.
- Sits between the compute-unit store sources and the write-merge buffer.

Parameters:
- NUM_REQ, 4, number of store requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NUM_REQ  per-requester store valid.
- req_addr  in  NUM_REQ*32  per-requester byte address, packed with requester i at [i*32 +: 32].
- req_wdata  in  NUM_REQ*32  per-requester store data.
- req_wstrb  in  NUM_REQ*4  per-requester byte strobes.
- req_ready  out  NUM_REQ  per-requester accept.
- wmb_valid  out  1  store to merge buffer.
- wmb_addr  out  32  muxed address.
- wmb_wdata  out  32  muxed data.
- wmb_wstrb  out  4  muxed strobes.
- wmb_ready  in  1  merge buffer accept.
- wmb_flush  out  1  flush request to merge buffer.
- wmb_busy  in  1  merge buffer holds data or is draining.
- fence_req  in  1  level fence request from the core.
- fence_ack  out  1  one-cycle pulse: fence complete.
- grant_idx  out  IDX_W  index of the currently granted requester (debug).

Behaviour:
- Reset (rst_n=0 at clk edge): state=ST_IDLE, rr_ptr=0, locked=0, fence_armed=1. While rst_n is low, all outputs are forced to 0 combinationally. A reset mid-store or mid-fence abandons the operation; no ack is issued.
- States:
  - ST_IDLE: arbitration is enabled.
  - ST_FENCE_QUIESCE: no new grants; a locked store is allowed to finish.
  - ST_FENCE_FLUSH: wmb_flush=1.
  - ST_FENCE_ACK: fence_ack=1 for one cycle.
- Arbitration (combinational, ST_IDLE only):
  - If locked, the grant is lock_idx.
  - Otherwise the grant is the first i with req_valid[i], searching from rr_ptr upward with wrap modulo NUM_REQ.
  - New (unlocked) grants are suppressed in any cycle where fence_req && fence_armed.
- Outputs: wmb_valid = req_valid[grant] while a grant exists. wmb_addr, wmb_wdata and wmb_wstrb are muxed from the granted requester and are 0 when there is no grant. req_ready[i] = grant_valid && (grant==i) && wmb_ready. Zero-latency pass-through; no storage.
- Lock: if wmb_valid && !wmb_ready, set locked=1 and lock_idx=grant. The requester must hold its payload stable until ready.
- Handshake: on wmb_valid && wmb_ready, clear locked and set rr_ptr=grant+1 (wrap).
- Per-requester ordering is preserved. No ordering is guaranteed between different requesters.
- Transitions:
  - IDLE -> FENCE_QUIESCE when fence_req && fence_armed; clear fence_armed.
  - FENCE_QUIESCE -> FENCE_FLUSH when !locked, or when the locked store handshakes this cycle.
  - The locked store's handshake remains legal in FENCE_QUIESCE.
  - FENCE_FLUSH: wmb_flush held high. -> FENCE_ACK on the first cycle wmb_busy==0 is sampled while wmb_flush=1 (minimum one flush cycle, even if the buffer is already empty).
  - FENCE_ACK -> IDLE unconditionally.
- fence_armed is set again when fence_req is sampled low in IDLE. A fence_req held high after ack therefore does not start a second fence.
- Fence latency with an empty buffer and no lock: req sampled at cycle 0; QUIESCE at cycle 1; FLUSH at cycle 2; ack asserted during cycle 3.
- wmb_flush is 0 in every state except FENCE_FLUSH.
- req_ready is 0 for all requesters in the FENCE states, except the locked requester in FENCE_QUIESCE.

Optional Feature:
- Macro WMB_ARB_STATS_EN.
- Defined: adds output stat_grant_cnt (NUM_REQ*16, saturating count of accepted stores per requester) and stat_stall_cnt (16, saturating count of cycles with wmb_valid && !wmb_ready). Both clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- All four requesters valid, wmb_ready=1 constantly -> grants 0,1,2,3,0 on consecutive cycles; each req_ready a single-cycle pulse.
- Req2 granted with wmb_ready=0 for 3 cycles while req0 and req1 assert valid -> grant_idx stays 2 and payload stable; req2 accepted on cycle 4; next grant is 3 if valid, else 0.
- fence_req with buffer empty and all requesters idle -> wmb_flush high for exactly 1 cycle; fence_ack pulse 3 cycles after fence_req is sampled; no req_ready during the fence.
- fence_req while req1 is locked and wmb_busy stays 1 for 5 flush cycles -> req1 completes first; wmb_flush high for 6 cycles; single fence_ack; then arbitration resumes at rr_ptr=2.
- fence_req held high for 10 cycles -> exactly one fence_ack; a second fence starts only after fence_req drops and rises again.
- rst_n low during FENCE_FLUSH -> next cycle wmb_flush=0, fence_ack=0, state IDLE, rr_ptr=0; no ack issued.
